rv_multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the RV32I core; successor to the single-cycle control unit.
- Latches the fetched instruction and walks an FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT/TRAP).
- Drives the datapath strobes: ALU op, immediate select, ALU source, PC source, register write-back and memory request/write.
- Adds a memory ready handshake with a timeout, a run enable, a halt on ECALL/EBREAK, and an illegal-opcode trap.

---
 rtl/rv_multicycle_ctrl_if.sv | 36 +++
 rtl/rv_multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface rv_multicycle_ctrl_if #(
    parameter int ALU_OP_W = 4
);
    logic                run_en;
    logic [31:0]         inst;
    logic                mem_ready;
    logic [3:0]          status;
    logic [31:0]         ir;
    logic                mem_req;
    logic                mem_we;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          imm_sel;
    logic                reg_we;
    logic [1:0]          wb_sel;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic                halted;
    logic                trap;
    logic [1:0]          trap_cause;
    logic [2:0]          state;

    modport master (
        input  run_en, inst, mem_ready, status,
        output ir, mem_req, mem_we, alu_src, alu_op, imm_sel, reg_we, wb_sel,
               pc_we, pc_src, halted, trap, trap_cause, state
    );

    modport slave (
        output run_en, inst, mem_ready, status,
        input  ir, mem_req, mem_we, alu_src, alu_op, imm_sel, reg_we, wb_sel,
               pc_we, pc_src, halted, trap, trap_cause, state
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: latches the fetched instruction and steps
// FETCH/DECODE/EXEC/MEM/WB, with memory timeout, halt on SYSTEM and illegal-opcode trap.
module rv_multicycle_ctrl #(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rv_multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             halted_q, trap_q;
    logic [1:0]       cause_q, cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic       is_system, is_known, br_legal, br_taken, mem_timeout;

    logic [3:0] ex_op;
    logic       ex_src;
    logic [2:0] ex_imm;

    logic       mem_req_c, mem_we_c, alu_src_c, reg_we_c, pc_we_c;
    logic [3:0] alu_op_c;
    logic [2:0] imm_sel_c;
    logic [1:0] wb_sel_c, pc_src_c;

    function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7_5  = ir_q[30];
    assign is_r      = (opcode == OPC_R);
    assign is_i      = (opcode == OPC_I);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_system = (opcode == OPC_SYSTEM);
    assign is_known  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr
                     | is_lui | is_auipc;
    assign br_legal  = (funct3[2:1] != 2'b01);

    // The counter holds the number of mem_ready-low cycles already spent in this access.
    assign mem_timeout = (MEM_TIMEOUT != 0) && !bus.mem_ready
                       && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        case (funct3)
            3'b000:  br_taken = bus.status[0];
            3'b001:  br_taken = !bus.status[0];
            3'b100:  br_taken = bus.status[1] ^ bus.status[3];
            3'b101:  br_taken = !(bus.status[1] ^ bus.status[3]);
            3'b110:  br_taken = !bus.status[2];
            3'b111:  br_taken = bus.status[2];
            default: br_taken = 1'b0;
        endcase
    end

    // ALU controls shared by EXEC and MEM, so an address stays stable across wait states.
    always_comb begin
        ex_op  = ALU_ADD;
        ex_src = 1'b0;
        ex_imm = IMM_I;
        case (opcode)
            OPC_R:      ex_op = f3_to_op(funct3, funct7_5);
            OPC_I: begin
                ex_src = 1'b1;
                ex_op  = f3_to_op(funct3, funct7_5 && (funct3 == 3'b101));
            end
            OPC_LOAD:   ex_src = 1'b1;
            OPC_STORE: begin
                ex_src = 1'b1;
                ex_imm = IMM_S;
            end
            OPC_LUI: begin
                ex_op  = ALU_PASSB;
                ex_imm = IMM_U;
            end
            OPC_AUIPC:  ex_imm = IMM_U;
            OPC_BRANCH: begin
                ex_op  = ALU_SUB;
                ex_imm = IMM_B;
            end
            OPC_JAL:    ex_imm = IMM_J;
            OPC_JALR:   ex_src = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q     <= 32'h0000_0013;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            if (state_q == S_FETCH && bus.mem_ready) ir_q <= bus.inst;
            if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready)
                cnt_q <= cnt_q + CNT_W'(1);
            else
                cnt_q <= '0;
            if (state_d == S_HALT) halted_q <= 1'b1;
            if (state_d == S_TRAP && state_q != S_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = 2'd0;
        case (state_q)
            S_IDLE:   if (bus.run_en) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
                else if (mem_timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (is_known) state_d = S_EXEC;
                else if (is_system) state_d = S_HALT;
                else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    if (br_legal) state_d = S_FETCH;
                    else begin
                        state_d = S_TRAP;
                        cause_d = 2'd1;
                    end
                end else if (is_load || is_store) state_d = S_MEM;
                else state_d = S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready) state_d = is_load ? S_WB : S_FETCH;
                else if (mem_timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
    end

    // An illegal branch funct3 asserts nothing in EXEC; it only heads to TRAP.
    always_comb begin
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        alu_src_c = 1'b0;
        alu_op_c  = ALU_ADD;
        imm_sel_c = IMM_I;
        reg_we_c  = 1'b0;
        wb_sel_c  = 2'd0;
        pc_we_c   = 1'b0;
        pc_src_c  = 2'd0;
        case (state_q)
            S_FETCH: mem_req_c = 1'b1;
            S_EXEC: begin
                if (!(is_branch && !br_legal)) begin
                    alu_op_c  = ex_op;
                    alu_src_c = ex_src;
                    imm_sel_c = ex_imm;
                    if (is_branch) begin
                        pc_we_c  = 1'b1;
                        pc_src_c = br_taken ? 2'd1 : 2'd0;
                    end
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = is_store;
                alu_op_c  = ex_op;
                alu_src_c = ex_src;
                imm_sel_c = ex_imm;
                pc_we_c   = is_store && bus.mem_ready;
            end
            S_WB: begin
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                wb_sel_c = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
                pc_src_c = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
            end
            default: ;
        endcase
    end

    assign bus.ir         = ir_q;
    assign bus.mem_req    = mem_req_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.alu_src    = alu_src_c;
    assign bus.alu_op     = ALU_OP_W'(alu_op_c);
    assign bus.imm_sel    = imm_sel_c;
    assign bus.reg_we     = reg_we_c;
    assign bus.wb_sel     = wb_sel_c;
    assign bus.pc_we      = pc_we_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.halted     = halted_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: an instruction-level reference model queues the
// expected per-cycle outputs and a negedge monitor compares them against the DUT.
module tb_rv_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [2:0]  state;
        logic [31:0] ir;
        logic        mem_req;
        logic        mem_we;
        logic        alu_src;
        logic [3:0]  alu_op;
        logic [2:0]  imm_sel;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        halted;
        logic        trap;
        logic [1:0]  trap_cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rv_multicycle_ctrl_if #(.ALU_OP_W(4)) bus ();

    rv_multicycle_ctrl #(.ALU_OP_W(4), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb_q[$];
    string       tag_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] cur_ir;
    logic        m_halted, m_trap;
    logic [1:0]  m_cause;

    function automatic bit known_opcode(input logic [6:0] o);
        return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    function automatic exp_t base_exp(input logic [2:0] s);
        exp_t e;
        e            = '0;
        e.state      = s;
        e.ir         = cur_ir;
        e.halted     = m_halted;
        e.trap       = m_trap;
        e.trap_cause = m_cause;
        return e;
    endfunction

    // Reference semantics of the EXEC step, written per instruction family.
    function automatic exp_t exec_exp(input logic [31:0] in, input logic [3:0] st);
        exp_t     e;
        int       op_base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [2:0] f3;
        bit       z, n, c, v, lt, take;
        e  = base_exp(3'd3);
        f3 = in[14:12];
        z  = st[0]; n = st[1]; c = st[2]; v = st[3];
        lt = n ^ v;
        case (in[6:0])
            7'h33: e.alu_op = 4'(op_base[f3] + ((in[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0));
            7'h13: begin
                e.alu_src = 1'b1;
                e.alu_op  = 4'(op_base[f3] + ((in[30] && f3 == 3'd5) ? 1 : 0));
            end
            7'h03: e.alu_src = 1'b1;
            7'h23: begin e.alu_src = 1'b1; e.imm_sel = 3'd1; end
            7'h37: begin e.alu_op = 4'd10; e.imm_sel = 3'd3; end
            7'h17: e.imm_sel = 3'd3;
            7'h63: begin
                case (f3)
                    3'd0:    take = z;
                    3'd1:    take = !z;
                    3'd4:    take = lt;
                    3'd5:    take = !lt;
                    3'd6:    take = !c;
                    default: take = c;
                endcase
                e.alu_op  = 4'd1;
                e.imm_sel = 3'd2;
                e.pc_we   = 1'b1;
                e.pc_src  = take ? 2'd1 : 2'd0;
            end
            7'h6F: e.imm_sel = 3'd4;
            7'h67: e.alu_src = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t mem_exp(input logic [31:0] in, input bit ready);
        exp_t e;
        bit   st;
        st        = (in[6:0] == 7'h23);
        e         = base_exp(3'd4);
        e.mem_req = 1'b1;
        e.mem_we  = st;
        e.alu_src = 1'b1;
        e.imm_sel = st ? 3'd1 : 3'd0;
        e.pc_we   = st && ready;
        return e;
    endfunction

    function automatic exp_t wb_exp(input logic [31:0] in);
        exp_t e;
        e        = base_exp(3'd5);
        e.reg_we = 1'b1;
        e.pc_we  = 1'b1;
        if (in[6:0] == 7'h03) e.wb_sel = 2'd1;
        else if (in[6:0] == 7'h6F || in[6:0] == 7'h67) e.wb_sel = 2'd2;
        if (in[6:0] == 7'h6F) e.pc_src = 2'd1;
        else if (in[6:0] == 7'h67) e.pc_src = 2'd2;
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic re, input logic [31:0] in,
                                 input logic mr, input logic [3:0] st, input bit chk,
                                 input exp_t e, input string tag);
        @(posedge clk);
        #1;
        rst           = r;
        bus.run_en    = re;
        bus.inst      = in;
        bus.mem_ready = mr;
        bus.status    = st;
        if (chk) begin
            sb_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    task automatic cyc(input logic mr, input logic [31:0] in, input logic [3:0] st,
                       input exp_t e, input string tag);
        applyStimulus(1'b0, 1'($urandom), in, mr, st, 1'b1, e, tag);
    endtask

    task automatic checkOutput();
        exp_t  e, a;
        string t;
        if (sb_q.size() == 0) return;
        e            = sb_q.pop_front();
        t            = tag_q.pop_front();
        a.state      = bus.state;
        a.ir         = bus.ir;
        a.mem_req    = bus.mem_req;
        a.mem_we     = bus.mem_we;
        a.alu_src    = bus.alu_src;
        a.alu_op     = bus.alu_op;
        a.imm_sel    = bus.imm_sel;
        a.reg_we     = bus.reg_we;
        a.wb_sel     = bus.wb_sel;
        a.pc_we      = bus.pc_we;
        a.pc_src     = bus.pc_src;
        a.halted     = bus.halted;
        a.trap       = bus.trap;
        a.trap_cause = bus.trap_cause;
        tests_run++;
        if (a !== e) begin
            tests_failed++;
            $display("[TB] FAIL %s @%0t: got state=%0d bundle=%h, expected state=%0d bundle=%h",
                     t, $time, a.state, a, e.state, e);
        end
    endtask

    always @(negedge clk) checkOutput();

    task automatic reset_seq(input int n);
        applyStimulus(1'b1, 1'b0, $urandom, 1'($urandom), 4'($urandom), 1'b0, '0, "");
        cur_ir   = 32'h0000_0013;
        m_halted = 1'b0;
        m_trap   = 1'b0;
        m_cause  = 2'd0;
        for (int i = 1; i < n; i++)
            applyStimulus(1'b1, 1'($urandom), $urandom, 1'($urandom), 4'($urandom), 1'b1,
                          base_exp(3'd0), "reset");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, $urandom, 1'($urandom), 4'($urandom), 1'b1,
                          base_exp(3'd0), "idle");
    endtask

    task automatic start_run();
        applyStimulus(1'b0, 1'b1, $urandom, 1'($urandom), 4'($urandom), 1'b1,
                      base_exp(3'd0), "idle_go");
    endtask

    task automatic enter_trap(input logic [1:0] c);
        m_trap  = 1'b1;
        m_cause = c;
        for (int i = 0; i < 4; i++) cyc(1'($urandom), $urandom, 4'($urandom), base_exp(3'd7), "trap");
    endtask

    task automatic enter_halt(input int n);
        m_halted = 1'b1;
        for (int i = 0; i < n; i++) cyc(1'($urandom), $urandom, 4'($urandom), base_exp(3'd6), "halt");
    endtask

    // One instruction from its first FETCH cycle; stopped=1 when it ends in HALT or TRAP.
    task automatic do_instr(input logic [31:0] in, input int fw, input int mw,
                            input logic [3:0] st, output bit stopped);
        exp_t e;
        bit   is_ls;
        stopped = 1'b0;
        for (int k = 0; k < fw; k++) begin
            e = base_exp(3'd1); e.mem_req = 1'b1;
            cyc(1'b0, $urandom, 4'($urandom), e, "fetch_wait");
            if (k == TIMEOUT - 1) begin enter_trap(2'd2); stopped = 1'b1; return; end
        end
        e = base_exp(3'd1); e.mem_req = 1'b1;
        cyc(1'b1, in, 4'($urandom), e, "fetch");
        cur_ir = in;
        cyc(1'($urandom), $urandom, 4'($urandom), base_exp(3'd2), "decode");
        if (in[6:0] == 7'h73) begin enter_halt(3); stopped = 1'b1; return; end
        if (!known_opcode(in[6:0])) begin enter_trap(2'd1); stopped = 1'b1; return; end
        if (in[6:0] == 7'h63 && in[14:13] == 2'b01) begin
            cyc(1'($urandom), $urandom, st, base_exp(3'd3), "exec_bad_branch");
            enter_trap(2'd1); stopped = 1'b1; return;
        end
        cyc(1'($urandom), $urandom, st, exec_exp(in, st), "exec");
        if (in[6:0] == 7'h63) return;
        is_ls = (in[6:0] == 7'h03) || (in[6:0] == 7'h23);
        if (is_ls) begin
            for (int k = 0; k < mw; k++) begin
                cyc(1'b0, $urandom, 4'($urandom), mem_exp(in, 1'b0), "mem_wait");
                if (k == TIMEOUT - 1) begin enter_trap(2'd2); stopped = 1'b1; return; end
            end
            cyc(1'b1, $urandom, 4'($urandom), mem_exp(in, 1'b1), "mem");
            if (in[6:0] == 7'h23) return;
        end
        cyc(1'($urandom), $urandom, 4'($urandom), wb_exp(in), "wb");
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  known[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [31:0] bits;
        logic [6:0]  opc;
        int          r;
        r    = int'($urandom_range(0, 99));
        bits = $urandom;
        if (r < 6) begin
            opc = 7'($urandom);
            while (known_opcode(opc) || opc == 7'h73) opc = 7'($urandom);
        end else if (r < 9) begin
            opc = 7'h73;
        end else begin
            opc = known[$urandom_range(0, 8)];
            if (opc == 7'h63 && bits[13] && !bits[14] && $urandom_range(0, 3) != 0) bits[14] = 1'b1;
        end
        return {bits[31:7], opc};
    endfunction

    task automatic restart();
        reset_seq(2);
        idle_cycles(int'($urandom_range(0, 2)));
        start_run();
    endtask

    initial begin
        bit stopped;
        rst           = 1'b1;
        bus.run_en    = 1'b0;
        bus.inst      = '0;
        bus.mem_ready = 1'b0;
        bus.status    = '0;
        cur_ir        = 32'h0000_0013;
        m_halted      = 1'b0;
        m_trap        = 1'b0;
        m_cause       = 2'd0;

        reset_seq(3);
        idle_cycles(5);
        start_run();
        do_instr(32'h002081B3, 0, 0, 4'h0, stopped);
        do_instr(32'h0000A183, 0, 3, 4'h0, stopped);
        do_instr(32'h00208463, 0, 0, 4'b0001, stopped);
        do_instr(32'h00208463, 2, 0, 4'b0000, stopped);
        do_instr(32'h0020A423, 1, 0, 4'h0, stopped);
        do_instr(32'h008000EF, 0, 0, 4'h0, stopped);
        do_instr(32'h000080E7, 0, 0, 4'h0, stopped);
        do_instr(32'h123450B7, 0, 0, 4'h0, stopped);
        do_instr(32'h00001097, 0, 0, 4'h0, stopped);
        do_instr(32'h4020D093, 0, 0, 4'h0, stopped);
        do_instr(32'h402081B3, TIMEOUT - 1, 0, 4'h0, stopped);
        do_instr(32'h0020A423, 0, TIMEOUT - 1, 4'h0, stopped);

        do_instr(32'h00000073, 0, 0, 4'h0, stopped);
        enter_halt(20);
        restart();
        do_instr(32'h002081B3, TIMEOUT + 4, 0, 4'h0, stopped);
        restart();
        do_instr(32'h0000007F, 0, 0, 4'h0, stopped);
        restart();
        do_instr(32'h0020A463, 0, 0, 4'h0, stopped);
        restart();
        do_instr(32'h0000A183, 0, TIMEOUT, 4'h0, stopped);
        restart();

        for (int i = 0; i < 250; i++) begin
            int fw, mw;
            fw = ($urandom_range(0, 39) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 39) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 3));
            do_instr(rand_instr(), fw, mw, 4'($urandom), stopped);
            if (stopped) restart();
        end

        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #(500_000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
